// File: rtl/fifo_pkg.sv
// Shared widths and types for the 128-bit synchronous FIFO.
package fifo_pkg;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] ptr_t;
  typedef logic [ADDR_W:0]   cnt_t;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array with one write port and one registered read port.
module fifo_mem #(
  parameter int unsigned DATA_W = fifo_pkg::DATA_W,
  parameter int unsigned DEPTH  = fifo_pkg::DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Array contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_128.sv
// Single-clock FIFO: pointers, occupancy count, acceptance logic and registered flags.
module sync_fifo_128 #(
  parameter int unsigned DATA_W        = fifo_pkg::DATA_W,
  parameter int unsigned DEPTH         = fifo_pkg::DEPTH,
  parameter int unsigned ALM_FULL_LVL  = 12,
  parameter int unsigned ALM_EMPTY_LVL = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wren,
  input  logic              i_rden,
  input  logic [DATA_W-1:0] data_in,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_alm_full,
  output logic              o_alm_empty,
  output logic [DATA_W-1:0] o_rddata
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullLvl     = DEPTH[AW:0];
  localparam logic [AW:0] AlmFullLvl  = ALM_FULL_LVL[AW:0];
  localparam logic [AW:0] AlmEmptyLvl = ALM_EMPTY_LVL[AW:0];

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_cnt;
  logic [AW:0]   w_cnt_d;
  logic          r_full;
  logic          r_empty;
  logic          r_alm_full;
  logic          r_alm_empty;
  logic          w_wr_acc;
  logic          w_rd_acc;

  // A write into a full FIFO is only legal when a read frees the slot on the same edge.
  assign w_wr_acc = i_wren & (~r_full | i_rden);
  assign w_rd_acc = i_rden & ~r_empty;

  always_comb begin
    w_cnt_d = r_cnt;
    unique case ({w_wr_acc, w_rd_acc})
      2'b10:   w_cnt_d = r_cnt + 1'b1;
      2'b01:   w_cnt_d = r_cnt - 1'b1;
      default: w_cnt_d = r_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_alm_full  <= 1'b0;
      r_alm_empty <= 1'b1;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_cnt       <= w_cnt_d;
      r_full      <= (w_cnt_d == FullLvl);
      r_empty     <= (w_cnt_d == '0);
      r_alm_full  <= (w_cnt_d >= AlmFullLvl);
      r_alm_empty <= (w_cnt_d <= AlmEmptyLvl);
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (AW)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_wr_acc & ~reset),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_in),
    .i_re    (w_rd_acc & ~reset),
    .i_raddr (r_rd_ptr),
    .o_rdata (o_rddata)
  );

  assign o_full      = r_full;
  assign o_empty     = r_empty;
  assign o_alm_full  = r_alm_full;
  assign o_alm_empty = r_alm_empty;

endmodule

// File: tb/tb_sync_fifo_128.sv
// Directed table-driven bench for sync_fifo_128 with a scoreboard phase for wrap-around.
module tb_sync_fifo_128;
  import fifo_pkg::*;

  logic  clk;
  logic  reset;
  logic  i_wren;
  logic  i_rden;
  data_t data_in;
  logic  o_full;
  logic  o_empty;
  logic  o_alm_full;
  logic  o_alm_empty;
  data_t o_rddata;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic       wren;
    logic       rden;
    data_t      din;
    data_t      exp_rd;
    logic [3:0] exp_flags; // {full, empty, alm_full, alm_empty}
  } vec_t;

  vec_t  vecs [34];
  data_t sb_q [$];
  data_t exp_rd;

  sync_fifo_128 dut (
    .clk         (clk),
    .reset       (reset),
    .i_wren      (i_wren),
    .i_rden      (i_rden),
    .data_in     (data_in),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_alm_full  (o_alm_full),
    .o_alm_empty (o_alm_empty),
    .o_rddata    (o_rddata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input data_t act, input data_t exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_flags(input string name, input logic [3:0] exp);
    check(name, data_t'({o_full, o_empty, o_alm_full, o_alm_empty}), data_t'(exp));
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cycle(input logic wr, input logic rd, input data_t d);
    i_wren  = wr;
    i_rden  = rd;
    data_in = d;
    @(posedge clk);
    #1;
    i_wren = 1'b0;
    i_rden = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    i_wren  = 1'b1;
    i_rden  = 1'b1;
    data_in = 128'hBEEF;

    // Vectors: 16 fills, one dropped write, 16 drains, one dropped read.
    for (int i = 0; i < 16; i++) begin
      vecs[i].wren      = 1'b1;
      vecs[i].rden      = 1'b0;
      vecs[i].din       = data_t'(i + 1);
      vecs[i].exp_rd    = '0;
      vecs[i].exp_flags = {(i + 1 == 16), 1'b0, (i + 1 >= 12), (i + 1 <= 4)};
    end
    vecs[16] = '{1'b1, 1'b0, 128'hDEAD, 128'h0, 4'b1010};
    for (int k = 0; k < 16; k++) begin
      vecs[17+k].wren      = 1'b0;
      vecs[17+k].rden      = 1'b1;
      vecs[17+k].din       = 128'hFFFF;
      vecs[17+k].exp_rd    = data_t'(k + 1);
      vecs[17+k].exp_flags = {1'b0, (15 - k == 0), (15 - k >= 12), (15 - k <= 4)};
    end
    vecs[33] = '{1'b0, 1'b1, 128'h0, 128'h10, 4'b0101};

    // Reset held two cycles with both requests active.
    repeat (2) @(posedge clk);
    #1;
    check_flags("reset_flags", 4'b0101);
    check("reset_rddata", o_rddata, '0);
    reset  = 1'b0;
    i_wren = 1'b0;
    i_rden = 1'b0;
    cycle(1'b0, 1'b0, '0);
    check_flags("reset_no_write", 4'b0101);

    for (int v = 0; v < 34; v++) begin
      cycle(vecs[v].wren, vecs[v].rden, vecs[v].din);
      check($sformatf("vec%0d_rddata", v), o_rddata, vecs[v].exp_rd);
      check_flags($sformatf("vec%0d_flags", v), vecs[v].exp_flags);
    end

    // Simultaneous read and write while full.
    for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b0, data_t'(i));
    check_flags("full_before_rw", 4'b1010);
    cycle(1'b1, 1'b1, 128'hAA);
    check("full_rw_rddata", o_rddata, 128'h1);
    check_flags("full_rw_flags", 4'b1010);
    for (int i = 2; i <= 16; i++) begin
      cycle(1'b0, 1'b1, '0);
      check($sformatf("full_drain%0d", i), o_rddata, data_t'(i));
    end
    cycle(1'b0, 1'b1, '0);
    check("full_drain_last", o_rddata, 128'hAA);
    check_flags("full_drain_empty", 4'b0101);

    // Simultaneous read and write while empty: only the write lands.
    cycle(1'b1, 1'b1, 128'h55);
    check("empty_rw_rddata", o_rddata, 128'hAA);
    check_flags("empty_rw_flags", 4'b0001);
    cycle(1'b0, 1'b1, '0);
    check("empty_rw_read", o_rddata, 128'h55);
    check_flags("empty_rw_after", 4'b0101);

    // Random interleaving against a scoreboard queue.
    exp_rd = 128'h55;
    for (int c = 0; c < 40; c++) begin
      logic  wr;
      logic  rd;
      data_t d;
      int    occ;
      wr  = ($urandom_range(0, 9) != 0);
      rd  = ($urandom_range(0, 3) != 0);
      d   = {$urandom, $urandom, $urandom, $urandom};
      occ = sb_q.size();
      if (rd && occ > 0) exp_rd = sb_q.pop_front();
      if (wr && (occ < 16 || rd)) sb_q.push_back(d);
      cycle(wr, rd, d);
      occ = sb_q.size();
      check($sformatf("rand%0d_rddata", c), o_rddata, exp_rd);
      check_flags($sformatf("rand%0d_flags", c),
                  {(occ == 16), (occ == 0), (occ >= 12), (occ <= 4)});
    end

    // Drain leftovers, refill to 7 entries, then reset mid-operation.
    while (sb_q.size() > 0) begin
      cycle(1'b0, 1'b1, '0);
      check("rand_drain", o_rddata, sb_q.pop_front());
    end
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, data_t'(128'h100 + i));
    check_flags("pre_reset_flags", 4'b0000);
    reset = 1'b1;
    cycle(1'b1, 1'b1, 128'h999);
    reset = 1'b0;
    check_flags("midreset_flags", 4'b0101);
    check("midreset_rddata", o_rddata, '0);
    cycle(1'b1, 1'b0, 128'h777);
    check_flags("post_reset_write", 4'b0001);
    cycle(1'b0, 1'b1, '0);
    check("post_reset_read", o_rddata, 128'h777);
    check_flags("post_reset_empty", 4'b0101);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sync_fifo_128.md
Name: sync_fifo_128

Overview:
Synchronous single-clock FIFO: the design under test that sits on the far side of the FIFO verification interface. It accepts the driver's i_wren/i_rden/data_in and returns o_rddata plus the full, empty, almost-full and almost-empty status flags sampled by the monitor. Storage is registered, read data is registered, and all flags are registered.

Parameters:
DATA_W, 128, data width in bits
DEPTH, 16, number of entries; must be a power of 2 and at least 4
ALM_FULL_LVL, 12, o_alm_full asserts when occupancy >= this value (1..DEPTH-1)
ALM_EMPTY_LVL, 4, o_alm_empty asserts when occupancy <= this value (1..DEPTH-1)

Ports:
clk  input  1  single clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
i_wren  input  1  write request
i_rden  input  1  read request
data_in  input  DATA_W  write data, captured on an accepted write
o_full  output  1  occupancy == DEPTH
o_empty  output  1  occupancy == 0
o_alm_full  output  1  occupancy >= ALM_FULL_LVL
o_alm_empty  output  1  occupancy <= ALM_EMPTY_LVL
o_rddata  output  DATA_W  registered read data

Behaviour:
- Reset (synchronous, active-high, one clock, reset port named reset; clock port named clk):
  - wr_ptr, rd_ptr and count go to 0.
  - o_empty=1, o_alm_empty=1, o_full=0, o_alm_full=0, o_rddata=0.
  - Memory contents are not cleared.
- Reset asserted mid-operation: all contents are discarded at that edge. Any wren/rden in the same cycle is ignored.
- Acceptance, evaluated on pre-edge state:
  - wr_acc = i_wren & (!o_full | i_rden)
  - rd_acc = i_rden & !o_empty
- Full with simultaneous read and write: both are accepted and count stays at DEPTH.
- Empty with simultaneous read and write: only the write is accepted. There is no fall-through, so o_rddata is unchanged.
- Write beyond full with no read: dropped silently, state unchanged.
- Read when empty: dropped silently, o_rddata holds its previous value.
- Write: mem[wr_ptr] <= data_in, then wr_ptr increments.
- Read: o_rddata <= mem[rd_ptr], then rd_ptr increments.
- Read latency: data for a read accepted at edge N is visible on o_rddata after edge N and stable until the next accepted read.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count is log2(DEPTH)+1 bits and changes by +1 on write only, -1 on read only, 0 on both.
- Flags are registered from next-count. They reflect the occupancy after the same edge that updates the pointers, with no extra cycle of lag.
- No state machine is required beyond the pointer/count datapath. Occupancy is the only state.

Decomposition:
- Shared package fifo_pkg holds:
  - localparam defaults DATA_W=128 and DEPTH=16
  - typedef data_t, logic [DATA_W-1:0]
  - ADDR_W = $clog2(DEPTH)
  - typedef ptr_t and typedef cnt_t (ADDR_W+1 bits)
- One natural sub-module, fifo_mem: simple dual-port register array.
  - One write port (we, waddr, wdata) and one registered read port (re, raddr, rdata).
- sync_fifo_128 keeps the pointers, count, acceptance logic and flags.

Test Plan:
- Reset check: hold reset for 2 cycles with wren=rden=1 -> o_empty=1, o_alm_empty=1, o_full=0, o_alm_full=0, o_rddata=0, and no write takes effect.
- Fill: 16 writes of 0x1..0x10 with no reads.
  - o_alm_empty deasserts after the 5th write.
  - o_alm_full asserts after the 12th write.
  - o_full asserts after the 16th write.
  - A 17th write of 0xDEAD is dropped.
- Drain: 16 reads after fill -> o_rddata = 0x1..0x10 in order, each value one edge after its read. Then o_empty=1, and a 17th read leaves o_rddata=0x10.
- Simultaneous at full: full FIFO, one cycle wren=1 with data_in=0xAA plus rden=1 -> o_rddata=0x1, o_full stays 1. A later drain ends with 0xAA.
- Simultaneous at empty: empty FIFO, wren=1 with data_in=0x55 plus rden=1 -> o_rddata unchanged, o_empty=0, count=1. The next read returns 0x55.
- Wrap and mid-operation reset: 40 random interleaved read/write cycles checked against a scoreboard queue with pointers wrapping at least twice. Then reset with 7 entries held -> o_empty=1 the cycle after reset, and the next write/read returns the new data only.
